// File: rtl/pll_lock_supervisor.sv
// PLL bring-up sequencer: reset pulse, lock wait, stability window, loss recovery.
// Define PLL_SUP_STATS_EN to add the loss_cnt / timeout_cnt statistics outputs.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 100,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1000,
  parameter int LOSS_FILTER   = 4,
  parameter int MAX_RETRY     = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       force_reinit,
  output logic       pll_rst,
  output logic       domain_rstn,
  output logic       locked,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
`ifdef PLL_SUP_STATS_EN
  ,
  output logic [7:0] loss_cnt,
  output logic [7:0] timeout_cnt
`endif
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STB_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] LOSS_LAST = 16'(LOSS_FILTER - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t      cur;
  logic [15:0] cnt;
  logic        sync1;
  logic        lock_s;
  logic [3:0]  retry_nxt;

  assign state     = cur;
  assign retry_nxt = (retry_cnt == 4'hf) ? 4'hf : retry_cnt + 4'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1       <= 1'b0;
      lock_s      <= 1'b0;
      cur         <= S_RST;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      domain_rstn <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      retry_cnt   <= '0;
`ifdef PLL_SUP_STATS_EN
      loss_cnt    <= '0;
      timeout_cnt <= '0;
`endif
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
      if (force_reinit) begin
        cur         <= S_RST;
        cnt         <= '0;
        retry_cnt   <= '0;
        fail        <= 1'b0;
        domain_rstn <= 1'b0;
        locked      <= 1'b0;
        pll_rst     <= 1'b1;
      end else begin
        unique case (cur)
          S_RST: begin
            if (cnt == RST_LAST) begin
              cur     <= S_WAIT;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_WAIT: begin
            if (lock_s) begin
              cur <= S_STABLE;
              cnt <= '0;
            end else if (cnt == TO_LAST) begin
              retry_cnt <= retry_nxt;
              cnt       <= '0;
              pll_rst   <= 1'b1;
`ifdef PLL_SUP_STATS_EN
              if (timeout_cnt != 8'hff)
                timeout_cnt <= timeout_cnt + 8'd1;
`endif
              if (retry_nxt == RETRY_MAX) begin
                cur  <= S_FAIL;
                fail <= 1'b1;
              end else begin
                cur <= S_RST;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_STABLE: begin
            // any low sample restarts the lock wait, not a retry
            if (!lock_s) begin
              cur <= S_WAIT;
              cnt <= '0;
            end else if (cnt == STB_LAST) begin
              cur         <= S_RUN;
              cnt         <= '0;
              domain_rstn <= 1'b1;
              locked      <= 1'b1;
              retry_cnt   <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_RUN: begin
            if (lock_s) begin
              cnt <= '0;
            end else if (cnt == LOSS_LAST) begin
              cur         <= S_RST;
              cnt         <= '0;
              pll_rst     <= 1'b1;
              domain_rstn <= 1'b0;
              locked      <= 1'b0;
`ifdef PLL_SUP_STATS_EN
              if (loss_cnt != 8'hff)
                loss_cnt <= loss_cnt + 8'd1;
`endif
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_FAIL: begin
            pll_rst     <= 1'b1;
            domain_rstn <= 1'b0;
            locked      <= 1'b0;
            fail        <= 1'b1;
          end
          default: begin
            cur         <= S_RST;
            cnt         <= '0;
            pll_rst     <= 1'b1;
            domain_rstn <= 1'b0;
            locked      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Covers bring-up, glitch filtering, stability abort, timeouts, re-init and async reset.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_lock;
  logic       force_reinit;
  logic       pll_rst;
  logic       domain_rstn;
  logic       locked;
  logic       fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
`ifdef PLL_SUP_STATS_EN
  logic [7:0] loss_cnt;
  logic [7:0] timeout_cnt;
`endif

  int passed = 0;
  int total  = 0;

  pll_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .LOSS_FILTER  (3),
    .MAX_RETRY    (2)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pll_lock    (pll_lock),
    .force_reinit(force_reinit),
    .pll_rst     (pll_rst),
    .domain_rstn (domain_rstn),
    .locked      (locked),
    .fail        (fail),
    .state       (state),
    .retry_cnt   (retry_cnt)
`ifdef PLL_SUP_STATS_EN
    ,
    .loss_cnt    (loss_cnt),
    .timeout_cnt (timeout_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic test_reset;
    resetn = 1'b0;
    pll_lock = 1'b0;
    force_reinit = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (pll_rst !== 1'b1) $display("FAIL rst_pll_rst got %b want 1", pll_rst); else passed++;
    total++; if (domain_rstn !== 1'b0) $display("FAIL rst_domain_rstn got %b want 0", domain_rstn); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL rst_locked got %b want 0", locked); else passed++;
    total++; if (fail !== 1'b0) $display("FAIL rst_fail got %b want 0", fail); else passed++;
    total++; if (state !== 3'd0) $display("FAIL rst_state got %0d want 0", state); else passed++;
    total++; if (retry_cnt !== 4'd0) $display("FAIL rst_retry got %0d want 0", retry_cnt); else passed++;
`ifdef PLL_SUP_STATS_EN
    total++; if (loss_cnt !== 8'd0 || timeout_cnt !== 8'd0)
      $display("FAIL rst_stats got %0d/%0d want 0/0", loss_cnt, timeout_cnt); else passed++;
`endif
  endtask

  task automatic test_clean_bringup;
    int n;
    int m;
    resetn = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++; if (n != 4) $display("FAIL boot_pulse_len got %0d want 4", n); else passed++;
    total++; if (state !== 3'd1) $display("FAIL boot_wait_state got %0d want 1", state); else passed++;
    repeat (10) @(negedge clk);
    total++; if (state !== 3'd1) $display("FAIL boot_still_wait got %0d want 1", state); else passed++;
    pll_lock = 1'b1;
    m = 0;
    while (state !== 3'd3 && m < 60) begin @(negedge clk); m++; end
    total++; if (m < 9 || m > 11) $display("FAIL boot_run_latency got %0d want 9..11", m); else passed++;
    total++; if (domain_rstn !== 1'b1) $display("FAIL boot_domain_rstn got %b want 1", domain_rstn); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL boot_locked got %b want 1", locked); else passed++;
    total++; if (retry_cnt !== 4'd0) $display("FAIL boot_retry got %0d want 0", retry_cnt); else passed++;
    total++; if (pll_rst !== 1'b0) $display("FAIL boot_pll_rst got %b want 0", pll_rst); else passed++;
  endtask

  task automatic test_glitch_filter;
    logic held;
    int k;
    int n;
    int m;
    held = 1'b1;
    pll_lock = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (state !== 3'd3 || domain_rstn !== 1'b1) held = 1'b0;
    end
    pll_lock = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (state !== 3'd3 || domain_rstn !== 1'b1) held = 1'b0;
    end
    total++; if (held !== 1'b1) $display("FAIL glitch_held got %b want 1", held); else passed++;
    pll_lock = 1'b0;
    k = 0;
    while (domain_rstn === 1'b1 && k < 20) begin @(negedge clk); k++; end
    total++; if (k != 5) $display("FAIL loss_latency got %0d want 5", k); else passed++;
    total++; if (state !== 3'd0) $display("FAIL loss_state got %0d want 0", state); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL loss_locked got %b want 0", locked); else passed++;
    pll_lock = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++; if (n != 4) $display("FAIL loss_pulse_len got %0d want 4", n); else passed++;
`ifdef PLL_SUP_STATS_EN
    total++; if (loss_cnt !== 8'd1) $display("FAIL loss_cnt got %0d want 1", loss_cnt); else passed++;
`endif
    m = 0;
    while (state !== 3'd3 && m < 60) begin @(negedge clk); m++; end
    total++; if (locked !== 1'b1) $display("FAIL loss_relock got %b want 1", locked); else passed++;
  endtask

  task automatic test_stability_abort;
    int m;
    pll_lock = 1'b0;
    m = 0;
    while (state !== 3'd1 && m < 40) begin @(negedge clk); m++; end
    total++; if (state !== 3'd1) $display("FAIL abort_pre_state got %0d want 1", state); else passed++;
    pll_lock = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (state !== 3'd2) $display("FAIL abort_stable got %0d want 2", state); else passed++;
    pll_lock = 1'b0;
    @(negedge clk);
    pll_lock = 1'b1;
    m = 0;
    while (state !== 3'd1 && m < 10) begin @(negedge clk); m++; end
    total++; if (state !== 3'd1) $display("FAIL abort_back_wait got %0d want 1", state); else passed++;
    total++; if (retry_cnt !== 4'd0) $display("FAIL abort_retry got %0d want 0", retry_cnt); else passed++;
    m = 0;
    while (state !== 3'd3 && m < 40) begin @(negedge clk); m++; end
    total++; if (m < 8 || m > 9) $display("FAIL abort_run_latency got %0d want 8..9", m); else passed++;
    total++; if (domain_rstn !== 1'b1) $display("FAIL abort_domain_rstn got %b want 1", domain_rstn); else passed++;
  endtask

  task automatic test_force_run;
    int n;
    force_reinit = 1'b1;
    @(negedge clk);
    force_reinit = 1'b0;
    total++; if (state !== 3'd0) $display("FAIL frun_state got %0d want 0", state); else passed++;
    total++; if (domain_rstn !== 1'b0) $display("FAIL frun_domain_rstn got %b want 0", domain_rstn); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL frun_locked got %b want 0", locked); else passed++;
    total++; if (pll_rst !== 1'b1) $display("FAIL frun_pll_rst got %b want 1", pll_rst); else passed++;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++; if (n != 4) $display("FAIL frun_pulse_len got %0d want 4", n); else passed++;
  endtask

  task automatic test_async_reset_stable;
    int m;
    m = 0;
    while (state !== 3'd2 && m < 20) begin @(negedge clk); m++; end
    total++; if (state !== 3'd2 || pll_rst !== 1'b0)
      $display("FAIL ares_pre got state %0d pll_rst %b want 2/0", state, pll_rst); else passed++;
    #2 resetn = 1'b0;
    #1;
    total++; if (pll_rst !== 1'b1) $display("FAIL ares_pll_rst got %b want 1", pll_rst); else passed++;
    total++; if (domain_rstn !== 1'b0) $display("FAIL ares_domain_rstn got %b want 0", domain_rstn); else passed++;
    total++; if (state !== 3'd0) $display("FAIL ares_state got %0d want 0", state); else passed++;
    @(negedge clk);
    pll_lock = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout_fail;
    int n;
    int w;
    logic held;
    resetn = 1'b1;
    for (int a = 1; a <= 2; a++) begin
      n = 0;
      while (pll_rst === 1'b1 && n < 50) begin @(negedge clk); n++; end
      total++; if (n != 4) $display("FAIL to_pulse%0d_len got %0d want 4", a, n); else passed++;
      w = 0;
      while (state === 3'd1 && w < 100) begin @(negedge clk); w++; end
      total++; if (w != 20) $display("FAIL to_window%0d got %0d want 20", a, w); else passed++;
      total++; if (retry_cnt !== 4'(a)) $display("FAIL to_retry%0d got %0d want %0d", a, retry_cnt, a); else passed++;
    end
    total++; if (state !== 3'd4) $display("FAIL to_fail_state got %0d want 4", state); else passed++;
    total++; if (fail !== 1'b1) $display("FAIL to_fail_flag got %b want 1", fail); else passed++;
    total++; if (pll_rst !== 1'b1) $display("FAIL to_pll_rst got %b want 1", pll_rst); else passed++;
    held = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (pll_rst !== 1'b1 || state !== 3'd4 || fail !== 1'b1 || domain_rstn !== 1'b0) held = 1'b0;
    end
    total++; if (held !== 1'b1) $display("FAIL to_sticky got %b want 1", held); else passed++;
`ifdef PLL_SUP_STATS_EN
    total++; if (timeout_cnt !== 8'd2) $display("FAIL timeout_cnt got %0d want 2", timeout_cnt); else passed++;
`endif
  endtask

  task automatic test_force_fail;
    int n;
    int m;
    force_reinit = 1'b1;
    @(negedge clk);
    force_reinit = 1'b0;
    total++; if (state !== 3'd0) $display("FAIL ffail_state got %0d want 0", state); else passed++;
    total++; if (fail !== 1'b0) $display("FAIL ffail_flag got %b want 0", fail); else passed++;
    total++; if (retry_cnt !== 4'd0) $display("FAIL ffail_retry got %0d want 0", retry_cnt); else passed++;
    total++; if (domain_rstn !== 1'b0) $display("FAIL ffail_domain_rstn got %b want 0", domain_rstn); else passed++;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin @(negedge clk); n++; end
    total++; if (n != 4) $display("FAIL ffail_pulse_len got %0d want 4", n); else passed++;
`ifdef PLL_SUP_STATS_EN
    total++; if (timeout_cnt !== 8'd2) $display("FAIL ffail_timeout_cnt got %0d want 2", timeout_cnt); else passed++;
`endif
    pll_lock = 1'b1;
    m = 0;
    while (state !== 3'd3 && m < 60) begin @(negedge clk); m++; end
    total++; if (locked !== 1'b1 || fail !== 1'b0)
      $display("FAIL ffail_relock got locked %b fail %b want 1/0", locked, fail); else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_glitch_filter();
    test_stability_abort();
    test_force_run();
    test_async_reset_stable();
    test_timeout_fail();
    test_force_fail();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
